// File: rtl/pipe_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_mem_arbiter
//  Purpose  : Shares a single-port, fixed-latency main memory between the
//             I-cache refill path and the D-cache refill/writeback path.
//             A grant moves one full cache line, word by word, in ascending
//             order. The D side has fixed priority over the I side.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_mem_arbiter #(
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_LAT        = 3,
  parameter int IDX_W          = 2
) (
  input  logic             clock,
  input  logic             reset,
  // I-cache refill port
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,
  output logic             i_done,
  // D-cache refill / writeback port
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_wack,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_done,
  // word indices of the current transfers
  output logic [IDX_W-1:0] i_widx,
  output logic [IDX_W-1:0] d_widx,
  // main memory port
  output logic             mem_en,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             busy
);

  // Latency counter must hold 0..MEM_LAT-1, and be at least one bit wide.
  localparam int                 c_LAT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_LAT_W-1:0] c_LAT_LAST  = c_LAT_W'(MEM_LAT - 1);
  localparam logic [IDX_W-1:0]   c_WORD_LAST = IDX_W'(WORDS_PER_LINE - 1);
  // Clearing these bits yields the line base; the word offset is ORed back
  // into the same bits, so an address never carries out of its line.
  localparam logic [31:0]        c_LINE_MASK = ~(32'(4 * WORDS_PER_LINE - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_k;
  logic [c_LAT_W-1:0] r_lat;
  logic               r_owner_d;
  logic               r_we;
  logic [31:0]        r_base;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_k_nxt;
  logic [c_LAT_W-1:0] w_lat_nxt;
  logic               w_owner_d_nxt;
  logic               w_we_nxt;
  logic [31:0]        w_base_nxt;
  logic               w_word_end;
  logic               w_rd_cap;
  logic               w_xfer_nxt;

  // Write data goes straight through: the cache drives the word selected by
  // d_widx, which is already stable for the whole word access.
  assign mem_wdata = d_wdata;

  // State and transfer-context registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_lat     <= '0;
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_base    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_lat     <= w_lat_nxt;
      r_owner_d <= w_owner_d_nxt;
      r_we      <= w_we_nxt;
      r_base    <= w_base_nxt;
    end
  end

  // Arbitration, word/latency sequencing and next-state selection.
  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_lat_nxt     = r_lat;
    w_owner_d_nxt = r_owner_d;
    w_we_nxt      = r_we;
    w_base_nxt    = r_base;
    w_word_end    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (d_req) begin
          w_owner_d_nxt = 1'b1;
          w_we_nxt      = d_we;
          w_base_nxt    = d_addr & c_LINE_MASK;
          w_k_nxt       = '0;
          w_lat_nxt     = '0;
          w_state_nxt   = S_XFER;
        end else if (i_req) begin
          w_owner_d_nxt = 1'b0;
          w_we_nxt      = 1'b0;
          w_base_nxt    = i_addr & c_LINE_MASK;
          w_k_nxt       = '0;
          w_lat_nxt     = '0;
          w_state_nxt   = S_XFER;
        end
      end
      S_XFER: begin
        if (r_lat == c_LAT_LAST) begin
          w_word_end = 1'b1;
          w_lat_nxt  = '0;
          if (r_k == c_WORD_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_k_nxt = r_k + 1'b1;
          end
        end else begin
          w_lat_nxt = r_lat + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Read data is captured on the last cycle of each word of a refill.
  assign w_rd_cap   = (r_state == S_XFER) && w_word_end && !r_we;
  assign w_xfer_nxt = (w_state_nxt == S_XFER);

  // Registered outputs, derived from the next transfer context so they line
  // up exactly with the cycle the state machine is in.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      d_wack   <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      i_widx   <= '0;
      d_widx   <= '0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mem_en   <= w_xfer_nxt;
      mem_we   <= w_xfer_nxt && w_we_nxt;
      mem_addr <= w_xfer_nxt ? (w_base_nxt | (32'(w_k_nxt) << 2)) : 32'd0;
      d_wack   <= w_xfer_nxt && w_we_nxt && (w_lat_nxt == c_LAT_LAST);
      i_rvalid <= w_rd_cap && !r_owner_d;
      d_rvalid <= w_rd_cap && r_owner_d;
      i_done   <= (w_state_nxt == S_DONE) && !w_owner_d_nxt;
      d_done   <= (w_state_nxt == S_DONE) && w_owner_d_nxt;
      busy     <= (w_state_nxt != S_IDLE);
      if (w_rd_cap && !r_owner_d) begin
        i_rdata <= mem_rdata;
        i_widx  <= r_k;
      end
      if (w_rd_cap && r_owner_d) begin
        d_rdata <= mem_rdata;
        d_widx  <= r_k;
      end
      // A writeback shows its word index for the whole word access.
      if (w_xfer_nxt && w_we_nxt) begin
        d_widx <= w_k_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_mem_arbiter
//  Purpose  : Scoreboard bench for pipe_mem_arbiter. Expected line transfers
//             are laid out on a cycle timeline when stimulus is issued; a
//             monitor pops and compares whenever the DUT shows activity.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_mem_arbiter;
  localparam int W     = 4;
  localparam int L     = 3;
  localparam int IDX_W = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0]      i_addr = '0, d_addr = '0, d_wdata, mem_rdata = '0;
  logic             i_rvalid, i_done, d_wack, d_rvalid, d_done;
  logic [31:0]      i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [IDX_W-1:0] i_widx, d_widx;
  logic             mem_en, mem_we, busy;
  logic [31:0]      wline [W];

  always #5 clock = ~clock;

  assign d_wdata = wline[d_widx];

  pipe_mem_arbiter #(.WORDS_PER_LINE(W), .MEM_LAT(L), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wack(d_wack),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .i_widx(i_widx), .d_widx(d_widx),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memories: reference view and device view -------------
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] dev_mem   [logic [31:0]];

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : a;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : a;
  endfunction

  // Fixed-latency memory: data is only valid on the L-th cycle an address is
  // held; writes commit on that same cycle.
  int          dev_cnt = 0;
  logic        dev_prev_en = 1'b0;
  logic [31:0] dev_prev_addr = '0;
  always @(negedge clock) begin
    if (mem_en) dev_cnt = (dev_prev_en && mem_addr == dev_prev_addr) ? dev_cnt + 1 : 1;
    else        dev_cnt = 0;
    dev_prev_en   = mem_en;
    dev_prev_addr = mem_addr;
    mem_rdata = (mem_en && dev_cnt == L) ? dev_rd(mem_addr) : (32'hDEAD_BEEF ^ mem_addr);
    if (mem_en && mem_we && dev_cnt == L) dev_mem[mem_addr] = mem_wdata;
  end

  // ---------------- scoreboard queues ----------------
  typedef struct { int cyc; logic [31:0] data; logic [IDX_W-1:0] idx; } ev_t;
  typedef struct { int cyc; logic [31:0] addr; logic we; logic [IDX_W-1:0] idx; } acc_t;
  ev_t  iq[$], dq[$], wq[$];
  acc_t mq[$];
  int   idq[$], ddq[$];

  // Lay out one line transfer whose request is sampled at posedge index t0.
  task automatic expect_line(input bit own_d, input bit we, input logic [31:0] addr, input int t0);
    logic [31:0] base;
    base = (addr / (4 * W)) * (4 * W);
    for (int k = 0; k < W; k++) begin
      acc_t a;
      ev_t  e;
      for (int j = 0; j < L; j++) begin
        a.cyc = t0 + k * L + j; a.addr = base + 32'(4 * k); a.we = we; a.idx = IDX_W'(k);
        mq.push_back(a);
      end
      e.idx = IDX_W'(k);
      if (we) begin
        e.cyc = t0 + k * L + L - 1; e.data = wline[k];
        wq.push_back(e);
        model_mem[base + 32'(4 * k)] = wline[k];
      end else begin
        e.cyc = t0 + k * L + L; e.data = model_rd(base + 32'(4 * k));
        if (own_d) dq.push_back(e); else iq.push_back(e);
      end
    end
    if (own_d) ddq.push_back(t0 + W * L); else idq.push_back(t0 + W * L);
  endtask

  function automatic int pending();
    return iq.size() + dq.size() + wq.size() + mq.size() + idq.size() + ddq.size();
  endfunction

  task automatic flush_all();
    iq.delete(); dq.delete(); wq.delete(); mq.delete(); idq.delete(); ddq.delete();
  endtask

  // ---------------- monitor ----------------
  bit mon_on = 1'b0;
  always @(posedge clock) begin
    #1;
    if (mon_on) begin
      if (mem_en) begin
        if (mq.size() == 0) chk("mem_en_unexpected", mem_en, 1'b0);
        else begin
          acc_t a;
          a = mq.pop_front();
          chk("mem_access", {cyc, mem_addr, mem_we, (a.we ? d_widx : a.idx)},
                            {a.cyc, a.addr, a.we, a.idx});
        end
      end else if (mem_we) chk("mem_we_without_en", mem_we, 1'b0);
      if (i_rvalid) begin
        if (iq.size() == 0) chk("i_rvalid_unexpected", i_rvalid, 1'b0);
        else begin
          ev_t e;
          e = iq.pop_front();
          chk("i_rvalid", {cyc, i_rdata, i_widx}, {e.cyc, e.data, e.idx});
        end
      end
      if (d_rvalid) begin
        if (dq.size() == 0) chk("d_rvalid_unexpected", d_rvalid, 1'b0);
        else begin
          ev_t e;
          e = dq.pop_front();
          chk("d_rvalid", {cyc, d_rdata, d_widx}, {e.cyc, e.data, e.idx});
        end
      end
      if (d_wack) begin
        if (wq.size() == 0) chk("d_wack_unexpected", d_wack, 1'b0);
        else begin
          ev_t e;
          e = wq.pop_front();
          chk("d_wack", {cyc, d_widx, mem_wdata}, {e.cyc, e.idx, e.data});
        end
      end
      if (i_done) begin
        if (idq.size() == 0) chk("i_done_unexpected", i_done, 1'b0);
        else chk("i_done_cycle", cyc, idq.pop_front());
      end
      if (d_done) begin
        if (ddq.size() == 0) chk("d_done_unexpected", d_done, 1'b0);
        else chk("d_done_cycle", cyc, ddq.pop_front());
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // which: 0 = i_done, 1 = d_done, 2 = i_rvalid
  task automatic wait_for(input int which, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < W * L + 8 && !seen; n++) begin
      tick();
      case (which)
        0:       seen = i_done;
        1:       seen = d_done;
        default: seen = i_rvalid;
      endcase
    end
    if (!seen) chk({name, "_timeout"}, seen, 1'b1);
  endtask

  task automatic set_wline();
    for (int k = 0; k < W; k++) wline[k] = $urandom;
  endtask

  task automatic run_single(input bit own_d, input bit we, input logic [31:0] addr, input bit drop_early);
    int t0;
    @(negedge clock);
    if (own_d) begin d_addr = addr; d_we = we; d_req = 1'b1; end
    else begin i_addr = addr; i_req = 1'b1; end
    t0 = cyc + 1;
    expect_line(own_d, we, addr, t0);
    tick();
    chk("busy_after_grant", busy, 1'b1);
    if (drop_early && !own_d) begin
      wait_for(2, "first_i_rvalid");
      i_req = 1'b0;
    end
    wait_for(own_d ? 1 : 0, own_d ? "d_done" : "i_done");
    d_req = 1'b0; i_req = 1'b0;
    tick();
    chk("busy_back_idle", busy, 1'b0);
    chk("queues_drained", pending(), 0);
  endtask

  task automatic run_both(input bit dwe, input logic [31:0] da, input logic [31:0] ia);
    int t0;
    @(negedge clock);
    d_addr = da; d_we = dwe; d_req = 1'b1;
    i_addr = ia; i_req = 1'b1;
    t0 = cyc + 1;
    expect_line(1'b1, dwe, da, t0);
    expect_line(1'b0, 1'b0, ia, t0 + W * L + 2);
    wait_for(1, "both_d_done");
    d_req = 1'b0;
    wait_for(0, "both_i_done");
    i_req = 1'b0;
    tick();
    chk("busy_back_idle", busy, 1'b0);
    chk("queues_drained", pending(), 0);
  endtask

  function automatic logic [107:0] all_outputs();
    return {i_rvalid, i_rdata, i_done, d_wack, d_rvalid, d_rdata, d_done,
            i_widx, d_widx, mem_en, mem_we, mem_addr, busy};
  endfunction

  logic [31:0] pool [6];

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    pool[0] = 32'h0040_0010; pool[1] = 32'h1000_0020; pool[2] = 32'hFFFF_FFF0;
    pool[3] = 32'h0000_0100; pool[4] = 32'h2000_0040; pool[5] = 32'h0000_0000;
    for (int k = 0; k < W; k++) wline[k] = '0;

    repeat (3) tick();
    chk("reset_outputs_zero", all_outputs(), '0);
    @(negedge clock);
    reset = 1'b0;
    mon_on = 1'b1;
    repeat (2) tick();
    chk("idle_no_busy", busy, 1'b0);

    // I refill with unaligned address: words 0x00400010..1C.
    run_single(1'b0, 1'b0, 32'h0040_0014, 1'b0);

    // Simultaneous requests: D refill first, then I.
    run_both(1'b0, 32'h2000_0040, 32'h0000_0100);

    // D writeback, then confirm memory holds the supplied words.
    set_wline();
    run_single(1'b1, 1'b1, 32'h1000_0020, 1'b0);
    for (int k = 0; k < W; k++)
      chk("writeback_mem_word", dev_rd(32'h1000_0020 + 32'(4 * k)), wline[k]);

    // Refill of the written line returns the written data.
    run_single(1'b1, 1'b0, 32'h1000_0028, 1'b0);

    // Reset during word 2 of an I refill.
    @(negedge clock);
    i_addr = 32'h0000_0108; i_req = 1'b1;
    t0 = cyc + 1;
    expect_line(1'b0, 1'b0, 32'h0000_0108, t0);
    while (cyc < t0 + 2 * L + 1) tick();
    reset = 1'b1;
    tick();
    flush_all();
    chk("reset_mid_xfer_outputs_zero", all_outputs(), '0);
    reset = 1'b0; i_req = 1'b0;
    repeat (W * L + 4) tick();
    run_single(1'b0, 1'b0, 32'h0000_0104, 1'b0);

    // I request dropped after the first word still completes.
    run_single(1'b0, 1'b0, 32'h0040_0018, 1'b1);

    // Top-of-memory line stays inside its line.
    run_single(1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0);

    // Randomised traffic.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a1, a2;
      int kind;
      kind = $urandom_range(0, 3);
      a1 = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 15));
      a2 = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) tick();
      case (kind)
        0: run_single(1'b0, 1'b0, a1, $urandom_range(0, 1) == 1);
        1: run_single(1'b1, 1'b0, a1, 1'b0);
        2: begin set_wline(); run_single(1'b1, 1'b1, a1, 1'b0); end
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            set_wline();
            run_both(1'b1, a1, a2);
          end else begin
            run_both(1'b0, a1, a2);
          end
        end
      endcase
    end

    repeat (4) tick();
    chk("final_queues_drained", pending(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
